// File: rtl/mux_pipe_pkg.sv
// Shared constants and helpers for the pipelined N:1 selector / round-robin arbiter.
package mux_pipe_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Minimum index width for a given channel count; never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_pipe_rr_grant.sv
// Rotating-priority encoder: picks the first requester after last_grant, wrapping modulo CHANNELS.
module rr_grant #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last_grant,
    output logic                gnt_valid,
    output logic [SEL_W-1:0]    gnt_idx
);

    // Walk offsets from farthest to nearest so the nearest requester is the last (winning) write.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % CHANNELS;
            if (req[SEL_W'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_pipe_rr.sv
// N-channel valid/ready selector with one registered output entry, explicit-select or
// round-robin grant, and a wrapping count of accepted transfers.
module mux_pipe_rr
    import mux_pipe_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 8,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          xfer_count
);

    localparam int SEL_N = 1 << SEL_W;

    logic [WIDTH-1:0] ch_data [CHANNELS];
    logic [SEL_N-1:0] valid_pad;

    logic             sel_hit;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic             can_load;
    logic             accept;

    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [SEL_W-1:0] out_chan_q,   out_chan_d;
    logic [CNT_W-1:0] xfer_count_q, xfer_count_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // Pad the request vector so an out-of-range sel reads a zero instead of indexing past the end.
    assign valid_pad = SEL_N'(in_valid);
    assign sel_hit   = (int'(sel) < CHANNELS) && valid_pad[sel];

    rr_grant #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_grant (
        .req        (in_valid),
        .last_grant (last_grant_q),
        .gnt_valid  (rr_valid),
        .gnt_idx    (rr_idx)
    );

    assign gnt_valid = (mode == MODE_RR) ? rr_valid : sel_hit;
    assign gnt_idx   = (mode == MODE_RR) ? rr_idx   : sel;
    assign can_load  = !out_valid_q || out_ready;

    // A grant only exists for a requesting channel, so a granted ready is always a handshake.
    assign accept = rst_n && can_load && gnt_valid;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
        assign in_ready[gi] = accept && (gnt_idx == SEL_W'(gi));
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        xfer_count_d = xfer_count_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = ch_data[gnt_idx];
            out_chan_d   = gnt_idx;
            xfer_count_d = xfer_count_q + CNT_W'(1);
            if (mode == MODE_RR) begin
                last_grant_d = gnt_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            xfer_count_q <= '0;
            last_grant_q <= SEL_W'(CHANNELS - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            xfer_count_q <= xfer_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_mux_pipe_rr.sv
// Self-checking bench: behavioural model compared every cycle, plus directed literal checks
// and a small 6-channel / 4-bit-counter instance for the boundary cases.
module tb_mux_pipe_rr;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mode;
    logic [2:0]      sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [2:0]      out_chan;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   xfer_count;

    logic            b_mode;
    logic [2:0]      b_sel;
    logic [6*8-1:0]  b_in_data;
    logic [5:0]      b_in_valid;
    logic [5:0]      b_in_ready;
    logic [7:0]      b_out_data;
    logic [2:0]      b_out_chan;
    logic            b_out_valid;
    logic            b_out_ready;
    logic [3:0]      b_xfer_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    always #5 clk = ~clk;

    mux_pipe_rr #(.WIDTH(W), .CHANNELS(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .sel        (sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    mux_pipe_rr #(.WIDTH(8), .CHANNELS(6), .CNT_W(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (b_mode),
        .sel        (b_sel),
        .in_data    (b_in_data),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .out_data   (b_out_data),
        .out_chan   (b_out_chan),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .xfer_count (b_xfer_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant rule: select mode takes sel if in range and requesting; round-robin takes
    // the first requester at last+1, last+2, ... modulo N. Returns -1 for no grant.
    function automatic int pick(input logic md, input int s, input logic [N-1:0] v, input int last);
        if (md == 1'b0) begin
            if (s < N && ((v >> s) & 1) != 0) return s;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (((v >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    // Model state: contents of the single output slot, transfer count and round-robin pointer.
    bit          m_valid;
    logic [W-1:0] m_data;
    int          m_chan;
    int          m_count;
    int          m_last;

    always @(negedge clk) begin
        if (!done) begin
            int          g;
            logic [N-1:0] er;
            if (!rst_n) begin
                m_valid = 1'b0;
                m_data  = '0;
                m_chan  = 0;
                m_count = 0;
                m_last  = N - 1;
            end
            g  = rst_n ? pick(mode, int'(sel), in_valid, m_last) : -1;
            er = '0;
            if (g >= 0 && (!m_valid || out_ready)) begin
                er = N'(1) << g;
            end
            chk("model_in_ready",   64'(in_ready),   64'(er));
            chk("model_out_valid",  64'(out_valid),  64'(m_valid));
            chk("model_out_data",   64'(out_data),   64'(m_data));
            chk("model_out_chan",   64'(out_chan),   64'(m_chan));
            chk("model_xfer_count", 64'(xfer_count), 64'(m_count));
            if (rst_n) begin
                if (er != '0) begin
                    m_data  = in_data[g*W +: W];
                    m_chan  = g;
                    m_valid = 1'b1;
                    m_count = (m_count + 1) % (1 << CW);
                    if (mode) m_last = g;
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [W-1:0] d);
        in_data[i*W +: W] = d;
    endtask

    initial begin
        int          rr_exp [5];
        logic [N-1:0] oh;
        rr_exp = '{0, 2, 5, 7, 0};

        rst_n       = 1'b1;
        mode        = 1'b0;
        sel         = 3'd5;
        in_valid    = '1;
        out_ready   = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, $urandom);
        b_mode      = 1'b0;
        b_sel       = 3'd0;
        b_in_data   = '0;
        b_in_valid  = '0;
        b_out_ready = 1'b1;
        #1 rst_n = 1'b0;

        // Held in reset with requests present: nothing may be granted.
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);

        // Select mode, sel=5.
        step();
        rst_n = 1'b1;
        set_ch(5, 32'hDEADBEEF);
        @(negedge clk);
        chk("sel_in_ready", 64'(in_ready), 64'h20);
        step();
        @(negedge clk);
        chk("sel_out_data",   64'(out_data),   64'hDEADBEEF);
        chk("sel_out_chan",   64'(out_chan),   64'd5);
        chk("sel_xfer_count", 64'(xfer_count), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("sel_sustain_count", 64'(xfer_count), 64'(2 + i));
            chk("sel_sustain_valid", 64'(out_valid),  64'd1);
        end

        // Asynchronous reset mid-cycle while the output holds data.
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid",  64'(out_valid),  64'h0);
        chk("arst_out_data",   64'(out_data),   64'h0);
        chk("arst_out_chan",   64'(out_chan),   64'h0);
        chk("arst_xfer_count", 64'(xfer_count), 64'h0);
        chk("arst_in_ready",   64'(in_ready),   64'h0);

        // Round-robin fairness from reset.
        step();
        rst_n    = 1'b1;
        mode     = 1'b1;
        in_valid = 8'b1010_0101;
        set_ch(0, 32'hA0A0_0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            oh = N'(1) << rr_exp[k];
            chk("rr_grant", 64'(in_ready), 64'(oh));
            step();
        end

        // Backpressure for 3 cycles after the last ch0 accept.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready),   64'h0);
            chk("bp_out_data", 64'(out_data),   64'hA0A0_0000);
            chk("bp_count",    64'(xfer_count), 64'd5);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_grant", 64'(in_ready), 64'h04);
        step();
        @(negedge clk);
        chk("bp_refill_chan",  64'(out_chan),   64'd2);
        chk("bp_refill_valid", 64'(out_valid),  64'd1);
        chk("bp_refill_count", 64'(xfer_count), 64'd6);

        // Mode switch: RR grants ch3, two select transfers on ch6, RR resumes at ch4.
        step();
        in_valid = 8'h08;
        @(negedge clk);
        chk("ms_rr_grant3", 64'(in_ready), 64'h08);
        step();
        mode     = 1'b0;
        sel      = 3'd6;
        in_valid = 8'hFF;
        @(negedge clk);
        chk("ms_sel_grant6", 64'(in_ready), 64'h40);
        step();
        @(negedge clk);
        chk("ms_sel_chan6", 64'(out_chan), 64'd6);
        step();
        mode = 1'b1;
        @(negedge clk);
        chk("ms_rr_resume4", 64'(in_ready), 64'h10);
        step();
        @(negedge clk);
        chk("ms_rr_chan4",  64'(out_chan),   64'd4);
        chk("ms_rr_count",  64'(xfer_count), 64'd11);

        // Randomised traffic, checked by the model every cycle.
        for (int t = 0; t < 3000; t++) begin
            step();
            rst_n     = ($urandom_range(0, 249) != 0);
            mode      = $urandom_range(0, 1) != 0;
            sel       = 3'($urandom_range(0, 7));
            in_valid  = N'($urandom) & N'($urandom | $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) set_ch(i, $urandom);
        end

        // Six channels: out-of-range select, then counter wrap at 4 bits.
        step();
        rst_n      = 1'b1;
        b_mode     = 1'b0;
        b_sel      = 3'd7;
        b_in_valid = 6'h3F;
        b_in_data  = 48'({$urandom, $urandom});
        @(negedge clk);
        chk("b_sel7_in_ready", 64'(b_in_ready), 64'h0);
        step();
        @(negedge clk);
        chk("b_sel7_out_valid", 64'(b_out_valid),  64'h0);
        chk("b_sel7_count",     64'(b_xfer_count), 64'h0);
        step();
        b_sel = 3'd2;
        for (int i = 0; i < 16; i++) begin
            step();
            @(negedge clk);
            chk("b_wrap_count", 64'(b_xfer_count), 64'((i + 1) % 16));
        end
        chk("b_wrap_chan",  64'(b_out_chan),  64'd2);
        chk("b_wrap_valid", 64'(b_out_valid), 64'd1);

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
